// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache controller among NUM_REQ requesters.
// Build macro ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts after TIMEOUT_CYCLES.
module cache_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int KEY_W          = 16,
    parameter int VAL_W          = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [KEY_W*NUM_REQ-1:0] req_key,
    input  logic [VAL_W*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [VAL_W-1:0]         resp_value,
    output logic                     resp_hit,
    output logic                     resp_err,
    output logic                     ctrl_start,
    output logic [2:0]               ctrl_op,
    output logic [KEY_W-1:0]         ctrl_key,
    output logic [VAL_W-1:0]         ctrl_value,
    input  logic                     ctrl_done,
    input  logic                     ctrl_hit,
    input  logic [VAL_W-1:0]         ctrl_rdata,
    output logic                     ctrl_abort,
    output logic                     busy
);
    localparam int         IDX_W   = $clog2(NUM_REQ);
    localparam logic [2:0] OP_READ = 3'd0;
    localparam logic [2:0] OP_MAX  = 3'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("cache_req_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXECUTE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             op_illegal;
    logic             timeout_hit;
    logic [2:0]       op_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;

    // First requesting index strictly after 'last', wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        int               cand;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last) + i) % NUM_REQ;
            idx  = IDX_W'(cand);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req    = |req_valid;
    assign winner     = rr_pick(req_valid, last_grant);
    assign op_illegal = (op_q > OP_MAX);
    assign busy       = (state != S_IDLE);
    assign ctrl_op    = op_q;
    assign ctrl_key   = key_q;
    assign ctrl_value = val_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == S_WAIT) && !ctrl_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ctrl_abort  = timeout_hit;

    // Cleared while in EXECUTE so the first WAIT cycle counts as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_EXECUTE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && !ctrl_done) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ctrl_abort  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        ctrl_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                // Illegal ops skip the controller and report an error directly.
                if (op_illegal) begin
                    state_nxt = S_COMPLETE;
                end else begin
                    ctrl_start = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ctrl_done || timeout_hit) begin
                    state_nxt = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            op_q       <= '0;
            key_q      <= '0;
            val_q      <= '0;
            resp_value <= '0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner <= winner;
                op_q  <= req_op[int'(winner)*3 +: 3];
                key_q <= req_key[int'(winner)*KEY_W +: KEY_W];
                val_q <= req_value[int'(winner)*VAL_W +: VAL_W];
            end
            if (state == S_EXECUTE && op_illegal) begin
                resp_value <= '0;
                resp_hit   <= 1'b0;
                resp_err   <= 1'b1;
            end
            if (state == S_WAIT) begin
                if (ctrl_done) begin
                    resp_value <= (op_q == OP_READ && ctrl_hit) ? ctrl_rdata : '0;
                    resp_hit   <= ctrl_hit;
                    resp_err   <= 1'b0;
                end else if (timeout_hit) begin
                    resp_value <= '0;
                    resp_hit   <= 1'b0;
                    resp_err   <= 1'b1;
                end
            end
            if (state == S_COMPLETE && resp_ready[owner]) begin
                last_grant <= owner;
            end
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: transaction-level model checked every cycle plus literal checks.
// Timeout scenarios are included when ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_cache_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int KEY_W   = 16;
    localparam int VAL_W   = 64;
    localparam int TO_CYC  = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [KEY_W*NUM_REQ-1:0] req_key;
    logic [VAL_W*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [VAL_W-1:0]         resp_value;
    logic                     resp_hit;
    logic                     resp_err;
    logic                     ctrl_start;
    logic [2:0]               ctrl_op;
    logic [KEY_W-1:0]         ctrl_key;
    logic [VAL_W-1:0]         ctrl_value;
    logic                     auto_done = 1'b0;
    logic                     stray_done;
    logic                     ctrl_hit;
    logic [VAL_W-1:0]         ctrl_rdata;
    logic                     ctrl_abort;
    logic                     busy;
    wire                      ctrl_done = auto_done | stray_done;

    cache_req_arbiter #(
        .NUM_REQ(NUM_REQ), .KEY_W(KEY_W), .VAL_W(VAL_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
        .resp_hit(resp_hit), .resp_err(resp_err),
        .ctrl_start(ctrl_start), .ctrl_op(ctrl_op), .ctrl_key(ctrl_key),
        .ctrl_value(ctrl_value), .ctrl_done(ctrl_done), .ctrl_hit(ctrl_hit),
        .ctrl_rdata(ctrl_rdata), .ctrl_abort(ctrl_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Controller stand-in: answers 'rsp_delay' cycles after each start pulse.
    int cyc       = 0;
    int start_cyc = -100;
    bit rsp_auto  = 1'b0;
    int rsp_delay = 1;

    always @(posedge clk) begin
        #1;
        cyc       = cyc + 1;
        auto_done = rsp_auto && (cyc == start_cyc + rsp_delay);
    end

    // Transaction model: one request in flight, aged in cycles since its accept.
    bit         m_busy, m_done, m_hit, m_err;
    int         m_owner, m_age, m_last;
    logic [2:0] m_op;
    logic [15:0] m_key;
    logic [63:0] m_val, m_rval;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_last = NUM_REQ - 1; m_owner = 0; m_age = 0;
            m_op = '0; m_key = '0; m_val = '0; m_rval = '0; m_hit = 0; m_err = 0;
        end else if (!m_busy) begin
            if (req_valid != '0) begin
                m_owner = rr_pick(req_valid, m_last);
                m_op    = req_op[3*m_owner +: 3];
                m_key   = req_key[KEY_W*m_owner +: KEY_W];
                m_val   = req_value[VAL_W*m_owner +: VAL_W];
                m_busy  = 1; m_done = 0; m_age = 1;
            end
        end else if (m_done) begin
            if (resp_ready[m_owner]) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end else if (m_age == 1) begin
            if (m_op > 3'd2) begin
                m_done = 1; m_hit = 0; m_err = 1; m_rval = '0;
            end else begin
                m_age = 2;
            end
        end else begin
            if (ctrl_done) begin
                m_done = 1; m_hit = ctrl_hit; m_err = 0;
                m_rval = (m_op == 3'd0 && ctrl_hit) ? ctrl_rdata : 64'd0;
            end else if (TIMEOUT_ON && (m_age - 2 == TO_CYC - 1)) begin
                m_done = 1; m_hit = 0; m_err = 1; m_rval = '0;
            end else begin
                m_age++;
            end
        end
    end

    // Event logs for the literal checks.
    int          grant_q[$], grant_cyc_q[$], start_cyc_q[$], start_key_q[$];
    int          rv_idx_q[$], rv_cyc_q[$], rv_hit_q[$], rv_err_q[$], abort_cyc_q[$];
    logic [63:0] rv_val_q[$];

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] e_ready, e_rv;
        logic               e_start, e_abort;
        e_ready = '0; e_rv = '0; e_start = 1'b0; e_abort = 1'b0;
        if (!m_busy) begin
            if (req_valid != '0) e_ready[rr_pick(req_valid, m_last)] = 1'b1;
        end else if (m_done) begin
            e_rv[m_owner] = 1'b1;
        end else if (m_age == 1) begin
            e_start = (m_op <= 3'd2);
        end else begin
            e_abort = TIMEOUT_ON && !ctrl_done && (m_age - 2 == TO_CYC - 1);
        end
        chk("req_ready", req_ready, e_ready);
        chk("resp_valid", resp_valid, e_rv);
        chk("ctrl_start", ctrl_start, e_start);
        chk("ctrl_abort", ctrl_abort, e_abort);
        chk("busy", busy, m_busy);
        chk("ctrl_op", ctrl_op, m_op);
        chk("ctrl_key", ctrl_key, m_key);
        chk("ctrl_value", ctrl_value, m_val);
        if (m_busy && m_done) begin
            chk("resp_value", resp_value, m_rval);
            chk("resp_hit", resp_hit, m_hit);
            chk("resp_err", resp_err, m_err);
        end
        if (req_ready != '0) begin
            grant_q.push_back(oh_idx(req_ready));
            grant_cyc_q.push_back(cyc);
        end
        if (ctrl_start) begin
            start_cyc_q.push_back(cyc);
            start_key_q.push_back(int'(ctrl_key));
            start_cyc = cyc;
        end
        if (resp_valid != '0) begin
            rv_idx_q.push_back(oh_idx(resp_valid));
            rv_cyc_q.push_back(cyc);
            rv_val_q.push_back(resp_value);
            rv_hit_q.push_back(int'(resp_hit));
            rv_err_q.push_back(int'(resp_err));
        end
        if (ctrl_abort) abort_cyc_q.push_back(cyc);
    end

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [63:0] qget64(input logic [63:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic clear_logs();
        grant_q.delete(); grant_cyc_q.delete(); start_cyc_q.delete(); start_key_q.delete();
        rv_idx_q.delete(); rv_cyc_q.delete(); rv_val_q.delete(); rv_hit_q.delete();
        rv_err_q.delete(); abort_cyc_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[5];
        int n1, last1, first1;
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req_valid = '0; resp_ready = '0; req_op = '0; req_key = '0;
        req_value = '0; ctrl_hit = 1'b0; ctrl_rdata = '0; stray_done = 1'b0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ctrl_start", ctrl_start, 0);
        chk("rst_ctrl_key", ctrl_key, 0);
        chk("rst_ctrl_abort", ctrl_abort, 0);
        rst_n = 1'b1;
        step(1);

        // Single READ from requester 0, done two cycles after start.
        req_op[2:0] = 3'd0; req_key[15:0] = 16'h1234; req_value[63:0] = 64'h1111;
        rsp_auto = 1'b1; rsp_delay = 2; ctrl_hit = 1'b1;
        ctrl_rdata = 64'hDEADBEEF_00C0FFEE; resp_ready = 4'hF;
        clear_logs();
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(6);
        chk("t1_grants", grant_q.size(), 1);
        chk("t1_grant_idx", qget(grant_q, 0), 0);
        chk("t1_start_lat", qget(start_cyc_q, 0) - qget(grant_cyc_q, 0), 1);
        chk("t1_ctrl_key", qget(start_key_q, 0), 16'h1234);
        chk("t1_resp_lat", qget(rv_cyc_q, 0) - qget(grant_cyc_q, 0), 4);
        chk("t1_resp_idx", qget(rv_idx_q, 0), 0);
        chk("t1_resp_value", qget64(rv_val_q, 0), 64'hDEADBEEF_00C0FFEE);
        chk("t1_resp_hit", qget(rv_hit_q, 0), 1);
        chk("t1_resp_err", qget(rv_err_q, 0), 0);

        // Round-robin with all four requesting continuously.
        do_reset();
        clear_logs();
        rsp_delay = 1;
        req_valid = 4'hF;
        step(18);
        req_valid = '0;
        step(6);
        chk("t2_grants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("t2_grant_order", qget(grant_q, i), exp_order[i]);
        for (int i = 1; i < 5; i++)
            chk("t2_grant_gap", qget(grant_cyc_q, i) - qget(grant_cyc_q, i - 1), 4);
        chk("t2_responses", rv_idx_q.size(), 5);

        // Illegal op from requester 2.
        req_op[8:6] = 3'd5; req_key[47:32] = 16'hABCD;
        clear_logs();
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(5);
        chk("t3_starts", start_cyc_q.size(), 0);
        chk("t3_grant_idx", qget(grant_q, 0), 2);
        chk("t3_responses", rv_idx_q.size(), 1);
        chk("t3_resp_idx", qget(rv_idx_q, 0), 2);
        chk("t3_resp_lat", qget(rv_cyc_q, 0) - qget(grant_cyc_q, 0), 2);
        chk("t3_resp_err", qget(rv_err_q, 0), 1);
        chk("t3_resp_hit", qget(rv_hit_q, 0), 0);
        chk("t3_resp_value", qget64(rv_val_q, 0), 64'd0);

        // Backpressure on an UPSERT from requester 1 while requester 0 waits.
        req_op[5:3] = 3'd1; req_key[31:16] = 16'hBEEF; req_value[127:64] = 64'hCAFE;
        ctrl_hit = 1'b1; ctrl_rdata = 64'h5555_5555_5555_5555; rsp_delay = 1;
        resp_ready = 4'b0001;
        clear_logs();
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b0001;
        step(7);
        resp_ready = 4'b0011;
        step(2);
        req_valid = '0;
        resp_ready = 4'hF;
        step(8);
        n1 = 0; last1 = -1; first1 = -1;
        for (int i = 0; i < rv_idx_q.size(); i++) begin
            if (rv_idx_q[i] == 1) begin
                n1++;
                last1 = rv_cyc_q[i];
                if (first1 < 0) first1 = i;
            end
        end
        chk("t4_resp_cycles", n1, 6);
        chk("t4_release_cyc", last1 - qget(grant_cyc_q, 0), 8);
        chk("t4_resp_value", qget64(rv_val_q, first1), 64'd0);
        chk("t4_resp_hit", qget(rv_hit_q, first1), 1);
        chk("t4_resp_err", qget(rv_err_q, first1), 0);
        chk("t4_grants", grant_q.size(), 2);
        chk("t4_grant0", qget(grant_q, 0), 1);
        chk("t4_grant1", qget(grant_q, 1), 0);
        chk("t4_grant_gap", qget(grant_cyc_q, 1) - qget(grant_cyc_q, 0), 9);

        // ctrl_done outside WAIT must be ignored.
        rsp_delay = 3;
        clear_logs();
        req_valid = 4'b0001;
        stray_done = 1'b1;
        step(1);
        req_valid = '0;
        step(1);
        stray_done = 1'b0;
        step(6);
        chk("t5_starts", start_cyc_q.size(), 1);
        chk("t5_resp_lat", qget(rv_cyc_q, 0) - qget(grant_cyc_q, 0), 5);
        chk("t5_resp_value", qget64(rv_val_q, 0), 64'h5555_5555_5555_5555);

        // Reset while in WAIT drops the transaction.
        rsp_auto = 1'b0;
        clear_logs();
        req_valid = 4'b1000;
        step(1);
        req_valid = '0;
        step(2);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ctrl_start", ctrl_start, 0);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_req_ready", req_ready, 0);
        step(2);
        rsp_auto = 1'b1; rsp_delay = 1;
        rst_n = 1'b1;
        req_valid = 4'b1001;
        step(1);
        req_valid = '0;
        step(6);
        chk("t6_grants", grant_q.size(), 2);
        chk("t6_grant_after_rst", qget(grant_q, 1), 0);
        chk("t6_responses", rv_idx_q.size(), 1);
        chk("t6_resp_idx", qget(rv_idx_q, 0), 0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog expiry, then done on the expiry cycle.
        rsp_auto = 1'b0;
        clear_logs();
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(12);
        chk("t7_aborts", abort_cyc_q.size(), 1);
        chk("t7_abort_cyc", qget(abort_cyc_q, 0) - qget(grant_cyc_q, 0), 9);
        chk("t7_resp_lat", qget(rv_cyc_q, 0) - qget(grant_cyc_q, 0), 10);
        chk("t7_resp_err", qget(rv_err_q, 0), 1);
        chk("t7_resp_hit", qget(rv_hit_q, 0), 0);
        chk("t7_resp_value", qget64(rv_val_q, 0), 64'd0);
        rsp_auto = 1'b1; rsp_delay = 8;
        clear_logs();
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(12);
        chk("t8_aborts", abort_cyc_q.size(), 0);
        chk("t8_resp_lat", qget(rv_cyc_q, 0) - qget(grant_cyc_q, 0), 10);
        chk("t8_resp_err", qget(rv_err_q, 0), 0);
        chk("t8_resp_hit", qget(rv_hit_q, 0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
Shares the single cache controller between NUM_REQ requesters using round-robin arbitration. Sequences each accepted request through the IDLE/EXECUTE/WAIT/COMPLETE transaction flow: accept, pulse start, wait for done, return the response. Sits between the requester-side interfaces and the cache controller. Carries READ/UPSERT/DELETE operations with a 16-bit key and 64-bit value.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_W, 16, key width
VAL_W, 64, value width
TIMEOUT_CYCLES, 1024, WAIT watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept pulse
req_op  in  3*NUM_REQ  per-requester op; 0=READ, 1=UPSERT, 2=DELETE
req_key  in  KEY_W*NUM_REQ  per-requester key
req_value  in  VAL_W*NUM_REQ  per-requester value
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-requester response accept
resp_value  out  VAL_W  shared response data
resp_hit  out  1  key found
resp_err  out  1  illegal op (or timeout)
ctrl_start  out  1  one-cycle start pulse to controller
ctrl_op  out  3  latched op
ctrl_key  out  KEY_W  latched key
ctrl_value  out  VAL_W  latched value
ctrl_done  in  1  controller completion pulse
ctrl_hit  in  1  controller hit result
ctrl_rdata  in  VAL_W  controller read data
ctrl_abort  out  1  watchdog abort pulse
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. Latched op/key/value = 0. last_grant = NUM_REQ-1, so requester 0 has top priority. A reset mid-transaction drops that transaction; no response is issued.
- IDLE: if any req_valid is set, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[winner]=1 for exactly one cycle; latch op/key/value and owner.
  - Next state: EXECUTE. If op > 2, next state is COMPLETE with err=1, hit=0, value=0; the controller is not started.
- EXECUTE: ctrl_start=1 for this single cycle. Next state: WAIT.
- ctrl_op/ctrl_key/ctrl_value are driven from the latched registers and stay stable from EXECUTE until the return to IDLE.
- WAIT: ctrl_done is sampled only in this state; ctrl_done in any other state is ignored. On ctrl_done=1: latch hit=ctrl_hit, err=0, and value=ctrl_rdata; go to COMPLETE.
  - value is forced to 0 when op != READ or ctrl_hit=0.
- COMPLETE: resp_valid[owner]=1 and all other resp_valid bits = 0; resp_value/resp_hit/resp_err are held stable.
  - Stays here until resp_ready[owner]=1. resp_ready from non-owners is ignored.
  - On the handshake: last_grant=owner, go to IDLE, resp_valid drops next cycle.
- Minimum request-to-response latency: accept (IDLE) → start (EXECUTE) → ≥1 WAIT cycle → resp_valid in the cycle after done. Best case, resp_valid asserts 3 cycles after req_ready.
- A new grant is possible in the cycle after the response handshake, so there is one IDLE cycle between transactions.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ transactions.
- req_valid changes while the arbiter is busy are ignored until the next IDLE.
- busy = (state != IDLE).

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without ctrl_done.
  - When count == TIMEOUT_CYCLES-1 and ctrl_done=0: ctrl_abort=1 for one cycle, latch err=1, hit=0, value=0, go to COMPLETE.
  - ctrl_done in the same cycle as expiry wins; no abort in that case.
- Not defined: WAIT waits indefinitely, ctrl_abort is tied 0, TIMEOUT_CYCLES is unused, and no counter is instantiated.

Test Plan:
- Single READ: req_valid=0001, op=0, key=0x1234; ctrl_done with hit=1, rdata=0xDEADBEEF_00C0FFEE 2 cycles after start → ctrl_start 1 cycle after req_ready[0], ctrl_key=0x1234, resp_valid=0001, resp_value=0xDEADBEEF_00C0FFEE, hit=1, err=0.
- Round-robin: req_valid=1111 held, each ctrl_done 1 cycle after start, resp_ready=1 → grant order 0,1,2,3,0, one IDLE cycle between transactions.
- Illegal op: requester 2 with op=5 → ctrl_start never asserts, resp_valid=0100 2 cycles after accept, err=1, hit=0, value=0.
- Backpressure: UPSERT from requester 1 completes with hit=1, resp_ready[1] held 0 for 5 cycles while resp_ready[0]=1 → resp_valid stays 0010, outputs stable, no new grant; releases 1 cycle after resp_ready[1]=1. resp_value=0 because op != READ.
- Reset mid-WAIT: rst_n=0 in WAIT → ctrl_start/resp_valid/busy=0 immediately; after release requester 0 wins over requester 3 when both are valid.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ctrl_done → ctrl_abort pulses on the 8th WAIT cycle, response has err=1, hit=0; with ctrl_done on that same cycle → no abort, err=0.
